// File: rtl/axil_drop_ctrl_regs_if.sv
// AXI4-Lite bus bundle for the drop-filter register block.
interface axil_drop_ctrl_regs_if #(
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  awvalid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awready;
    logic                  wvalid;
    logic [31:0]           wdata;
    logic                  wready;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  bready;
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rready;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_drop_ctrl_regs.sv
// AXI4-Lite register file for the plugin drop filter: drop enable, scratch,
// and saturating drop/pass packet counters.
module axil_drop_ctrl_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [15:0] BLOCK_ID   = 16'hD120
) (
    input  logic                        axil_aclk,
    input  logic                        axil_rst,
    axil_drop_ctrl_regs_if.slave        s_axil,
    input  logic                        pkt_drop,
    input  logic                        pkt_pass,
    output logic                        drop_en
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFF_W  = 10;

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [DATA_W-1:0]     CNT_MAX     = '1;

    localparam logic [OFF_W-1:0] OFF_CTRL     = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_STATUS   = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_DROP_CNT = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_PASS_CNT = OFF_W'(3);
    localparam logic [OFF_W-1:0] OFF_SCRATCH  = OFF_W'(4);

    function automatic logic hit_window(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:12] == BASE_A[ADDR_WIDTH-1:12];
    endfunction

    function automatic logic [DATA_W-1:0] cnt_next(input logic [DATA_W-1:0] cnt,
                                                   input logic pulse,
                                                   input logic clr);
        if (clr) begin
            return '0;
        end
        if (pulse && (cnt != CNT_MAX)) begin
            return cnt + DATA_W'(1);
        end
        return cnt;
    endfunction

    // Write channel state
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;

    // Read channel state
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    // Register contents
    logic                  drop_en_q,  drop_en_d;
    logic [DATA_W-1:0]     scratch_q,  scratch_d;
    logic [DATA_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic [DATA_W-1:0]     pass_cnt_q, pass_cnt_d;

    logic                  aw_hs_c;
    logic                  w_hs_c;
    logic                  b_hs_c;
    logic                  ar_hs_c;
    logic                  r_hs_c;
    logic                  wr_commit_c;
    logic                  wr_hit_c;
    logic [OFF_W-1:0]      wr_off_c;
    logic                  cnt_clr_c;
    logic [DATA_W-1:0]     rd_data_c;
    logic [1:0]            rd_resp_c;
    logic                  unused_addr_lsb;

    assign aw_hs_c     = s_axil.awvalid & awready_q;
    assign w_hs_c      = s_axil.wvalid  & wready_q;
    assign b_hs_c      = bvalid_q & s_axil.bready;
    assign ar_hs_c     = s_axil.arvalid & arready_q;
    assign r_hs_c      = rvalid_q & s_axil.rready;
    // A write commits one edge after both beats are held and no response is pending.
    assign wr_commit_c = ~awready_q & ~wready_q & ~bvalid_q;
    assign wr_hit_c    = hit_window(awaddr_q);
    assign wr_off_c    = awaddr_q[11:2];

    assign unused_addr_lsb = ^{awaddr_q[1:0], s_axil.araddr[1:0]};

    // Read decode from current register state (pre-edge snapshot)
    always_comb begin : rd_mux
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        if (!hit_window(s_axil.araddr)) begin
            rd_resp_c = RESP_SLVERR;
        end else begin
            case (s_axil.araddr[11:2])
                OFF_CTRL:     rd_data_c = {31'd0, drop_en_q};
                OFF_STATUS:   rd_data_c = {BLOCK_ID, 15'd0, drop_en_q};
                OFF_DROP_CNT: rd_data_c = drop_cnt_q;
                OFF_PASS_CNT: rd_data_c = pass_cnt_q;
                OFF_SCRATCH:  rd_data_c = scratch_q;
                default:      rd_data_c = '0;
            endcase
        end
    end

    // Write address/data capture, register update and response
    always_comb begin : wr_path
        awready_d = awready_q;
        wready_d  = wready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        drop_en_d = drop_en_q;
        scratch_d = scratch_q;
        cnt_clr_c = 1'b0;

        if (aw_hs_c) begin
            awaddr_d  = s_axil.awaddr;
            awready_d = 1'b0;
        end
        if (w_hs_c) begin
            wdata_d  = s_axil.wdata;
            wready_d = 1'b0;
        end
        if (wr_commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_hit_c ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit_c) begin
                case (wr_off_c)
                    OFF_CTRL: begin
                        drop_en_d = wdata_q[0];
                        cnt_clr_c = wdata_q[1];
                    end
                    OFF_SCRATCH: scratch_d = wdata_q;
                    default: ;
                endcase
            end
        end
        if (b_hs_c) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
    end

    // Read response capture; arready stays low while a response is pending
    always_comb begin : rd_path
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs_c) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_data_c;
            rresp_d   = rd_resp_c;
        end
        if (r_hs_c) begin
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
        end
    end

    // Saturating counters; a clear on the same edge as a pulse wins
    always_comb begin : cnt_path
        drop_cnt_d = cnt_next(drop_cnt_q, pkt_drop, cnt_clr_c);
        pass_cnt_d = cnt_next(pass_cnt_q, pkt_pass, cnt_clr_c);
    end

    always_ff @(posedge axil_aclk or posedge axil_rst) begin : state_reg
        if (axil_rst) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            drop_en_q  <= 1'b0;
            scratch_q  <= '0;
            drop_cnt_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            drop_en_q  <= drop_en_d;
            scratch_q  <= scratch_d;
            drop_cnt_q <= drop_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign drop_en        = drop_en_q;

endmodule
